// File: rtl/sap1_pkg.sv
// sap1_pkg: shared opcodes, one-hot T-states and control-word layout for the SAP-1 sequencer
package sap1_pkg;
  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;
  typedef struct packed {
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  } ctrl_t;
endpackage

// File: rtl/controller_sequencer_if.sv
// controller_sequencer_if: run/opcode inputs and clr_out, t_state, control word, hlt outputs
// master = instruction-side driver, slave = sequencer
interface controller_sequencer_if #(parameter int OPW = 4);
  logic run;
  logic [OPW-1:0] opcode;
  logic clr_out;
  logic [5:0] t_state;
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  logic hlt;
  modport master (output run, opcode,
                  input clr_out, t_state, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt);
  modport slave (input run, opcode,
                 output clr_out, t_state, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt);
endinterface

// File: rtl/ring_counter.sv
// ring_counter: one-hot six-state T counter with hold, T6->T1 wrap and load-T1
// ports: clk, clr_n (sync active-low), adv (step), load (return to T1 on this step), state
module ring_counter
  import sap1_pkg::*;
(
  input  logic     clk,
  input  logic     clr_n,
  input  logic     adv,
  input  logic     load,
  output t_state_e state
);
  t_state_e nxt;
  always_ff @(posedge clk)
    if (!clr_n) state <= T1;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (load) nxt = T1;
    else if (adv)
      case (state)
        T1: nxt = T2;
        T2: nxt = T3;
        T3: nxt = T4;
        T4: nxt = T5;
        T5: nxt = T6;
        default: nxt = T1;
      endcase
  end
endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 T-state sequencer and control-word decoder
// ports: clk, clr_n (sync active-low reset), bus (run, opcode in; clr_out, t_state, control bits, hlt out)
// SEQ_EARLY_RETIRE_EN: when defined, LDA/OUT/NOP return to T1 after their last active state
module controller_sequencer
  import sap1_pkg::*;
#(
  parameter int OPW = 4
) (
  input logic clk,
  input logic clr_n,
  controller_sequencer_if.slave bus
);
  t_state_e t;
  ctrl_t c;
  logic halted, adv, retire;
  logic is_lda, is_add, is_sub, is_out, is_hlt;
  assign is_lda = bus.opcode == OPW'(LDA);
  assign is_add = bus.opcode == OPW'(ADD);
  assign is_sub = bus.opcode == OPW'(SUB);
  assign is_out = bus.opcode == OPW'(OUT);
  assign is_hlt = bus.opcode == OPW'(HLT);
  assign adv = bus.run & ~halted;
  // Halt latches on the step into T4 so the frozen T4 cycle already shows hlt
  always_ff @(posedge clk)
    if (!clr_n) halted <= 1'b0;
    else if (adv && t == T3 && is_hlt) halted <= 1'b1;
`ifdef SEQ_EARLY_RETIRE_EN
  assign retire = is_lda ? t == T5 : (is_add | is_sub | is_hlt) ? 1'b0 : t == T4;
`else
  assign retire = 1'b0;
`endif
  ring_counter u_ring (
    .clk  (clk),
    .clr_n(clr_n),
    .adv  (adv),
    .load (adv & retire),
    .state(t)
  );
  always_comb begin
    c = '0;
    case (t)
      T1: {c.ep, c.lm} = 2'b11;
      T2: c.cp = 1'b1;
      T3: {c.ce, c.li} = 2'b11;
      T4:
        if (is_lda | is_add | is_sub) {c.ei, c.lm} = 2'b11;
        else if (is_out) {c.ea, c.lo} = 2'b11;
      T5:
        if (is_lda) {c.ce, c.la} = 2'b11;
        else if (is_add | is_sub) {c.ce, c.lb} = 2'b11;
      T6:
        if (is_add | is_sub) {c.eu, c.la, c.su} = {2'b11, is_sub};
      default: ;
    endcase
    if (!clr_n || !bus.run || halted) c = '0;
  end
  assign {bus.cp, bus.ep, bus.lm, bus.ce, bus.li, bus.ei,
          bus.la, bus.ea, bus.su, bus.eu, bus.lb, bus.lo} = c;
  assign bus.t_state = t;
  assign bus.hlt = halted & clr_n;
  assign bus.clr_out = ~clr_n;
endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer: directed scoreboard bench for controller_sequencer
module tb_controller_sequencer;
  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;
  localparam logic [3:0] O_LDA = 4'b0000, O_ADD = 4'b0001, O_SUB = 4'b0010;
  localparam logic [3:0] O_OUT = 4'b1110, O_HLT = 4'b1111, O_NOP = 4'b0101;
`ifdef SEQ_EARLY_RETIRE_EN
  localparam int LEN_LDA = 5, LEN_OUT = 4, LEN_NOP = 4;
`else
  localparam int LEN_LDA = 6, LEN_OUT = 6, LEN_NOP = 6;
`endif
  typedef logic [11:0] cw_a [6];
  localparam cw_a K_LDA = '{EP|LM, CP, CE|LI, EI|LM, CE|LA, 12'h000};
  localparam cw_a K_ADD = '{EP|LM, CP, CE|LI, EI|LM, CE|LB, EU|LA};
  localparam cw_a K_SUB = '{EP|LM, CP, CE|LI, EI|LM, CE|LB, SU|EU|LA};
  localparam cw_a K_OUT = '{EP|LM, CP, CE|LI, EA|LO, 12'h000, 12'h000};
  localparam cw_a K_NOP = '{EP|LM, CP, CE|LI, 12'h000, 12'h000, 12'h000};
  typedef struct {
    string name;
    logic [19:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic clr_n;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  controller_sequencer_if #(.OPW(4)) bus ();
  controller_sequencer #(.OPW(4)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      logic [19:0] got;
      e = q.pop_front();
      got = {bus.clr_out, bus.hlt, bus.t_state, bus.cp, bus.ep, bus.lm, bus.ce, bus.li,
             bus.ei, bus.la, bus.ea, bus.su, bus.eu, bus.lb, bus.lo};
      checks++;
      if (got !== e.v) begin
        failures++;
        $display("FAIL %s: got clr_out=%b hlt=%b t=%b ctrl=%b, want clr_out=%b hlt=%b t=%b ctrl=%b",
                 e.name, got[19], got[18], got[17:12], got[11:0],
                 e.v[19], e.v[18], e.v[17:12], e.v[11:0]);
      end
    end
  task automatic step(input logic c, input logic r, input logic [3:0] op,
                      input logic [5:0] t, input logic [11:0] k, input logic h, input string nm);
    @(posedge clk);
    #1;
    clr_n = c;
    bus.run = r;
    bus.opcode = op;
    q.push_back('{nm, {~c, h, t, k}});
  endtask
  task automatic instr(input logic [3:0] op, input int first, input int last, input cw_a k,
                       input string nm);
    for (int i = first; i < last; i++) step(1'b1, 1'b1, op, 6'(1 << i), k[i], 1'b0, nm);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    clr_n = 1'b0;
    bus.run = 1'b0;
    bus.opcode = O_LDA;
    step(1'b0, 1'b0, O_LDA, 6'b000001, 12'h000, 1'b0, "reset0");
    step(1'b0, 1'b0, O_LDA, 6'b000001, 12'h000, 1'b0, "reset1");
    instr(O_LDA, 0, LEN_LDA, K_LDA, "lda");
    instr(O_ADD, 0, 6, K_ADD, "add");
    instr(O_SUB, 0, 6, K_SUB, "sub");
    instr(O_OUT, 0, LEN_OUT, K_OUT, "out");
    instr(O_NOP, 0, LEN_NOP, K_NOP, "nop");
    instr(O_LDA, 0, LEN_LDA, K_LDA, "lda_after_nop");
    instr(O_ADD, 0, 2, K_ADD, "add_pre_pause");
    repeat (3) step(1'b1, 1'b0, O_ADD, 6'b000100, 12'h000, 1'b0, "pause");
    step(1'b1, 1'b1, O_ADD, 6'b000100, CE|LI, 1'b0, "resume");
    instr(O_ADD, 3, 6, K_ADD, "add_post_pause");
    instr(O_LDA, 0, 3, K_LDA, "lda_pre_clr");
    step(1'b0, 1'b1, O_LDA, 6'b001000, 12'h000, 1'b0, "mid_clr");
    instr(O_LDA, 0, LEN_LDA, K_LDA, "lda_post_clr");
    instr(O_HLT, 0, 3, K_LDA, "hlt_fetch");
    step(1'b1, 1'b1, O_HLT, 6'b001000, 12'h000, 1'b1, "hlt_t4");
    repeat (10) step(1'b1, 1'b1, O_HLT, 6'b001000, 12'h000, 1'b1, "hlt_hold");
    step(1'b0, 1'b1, O_HLT, 6'b001000, 12'h000, 1'b0, "hlt_clr");
    instr(O_LDA, 0, LEN_LDA, K_LDA, "lda_post_hlt");
    instr(O_SUB, 0, 6, K_SUB, "sub_final");
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 SHALL have parameter OPW, default 4, opcode width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port clr_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port run  input  1  high = advance the ring counter; low = pause.
REQ-005 SHALL have port opcode  input  OPW  upper nibble from the instruction register.
REQ-006 SHALL have port clr_out  output  1  active-high clear for the program counter and registers; equals ~clr_n.
REQ-007 SHALL have port t_state  output  6  one-hot ring state, T1=000001 through T6=100000.
REQ-008 SHALL have ports cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo  output  1 each  active-high control word bits.
REQ-009 SHALL have port hlt  output  1  high while halted.

Function
REQ-010 SHALL advance t_state one position per clk edge while run=1 and not halted, wrapping T6->T1.
REQ-011 SHALL decode control outputs combinationally from the registered t_state and opcode, with no extra cycle of latency.
REQ-012 SHALL drive the fetch states for every opcode as: T1 ep,lm; T2 cp; T3 ce,li.
REQ-013 SHALL drive LDA (0000) execute states as: T4 ei,lm; T5 ce,la; T6 none.
REQ-014 SHALL drive ADD (0001) execute states as: T4 ei,lm; T5 ce,lb; T6 eu,la.
REQ-015 SHALL drive SUB (0010) identically to ADD, with su also high in T6.
REQ-016 SHALL drive OUT (1110) execute states as: T4 ea,lo; T5 and T6 none.
REQ-017 SHALL, for HLT (1111) on entering T4, set a halted flag, assert hlt, freeze t_state at T4 and drive all other controls low until reset.
REQ-018 SHALL treat any other opcode as a NOP, with T4-T6 control outputs all zero.
REQ-019 SHALL hold t_state when run=0 and force all control outputs low, so cp is never asserted while paused.
REQ-020 SHALL assert cp in exactly one cycle per instruction.
REQ-021 SHALL, when run rises mid-instruction, resume from the held state and emit that state's controls.

Reset
REQ-022 SHALL, on any clk edge with clr_n=0, set t_state=T1 and clear the halted flag; this overrides run and halt.
REQ-023 SHALL force all control outputs and hlt to 0 while clr_n=0, and drive clr_out=1.
REQ-024 SHALL take effect when reset is asserted mid-instruction, with no completion of the current instruction.
REQ-025 SHALL emit ep and lm in the first cycle after clr_n rises.

Configuration
REQ-026 SHALL use the macro SEQ_EARLY_RETIRE_EN to select the execute-cycle behaviour.
REQ-027 SHALL, when SEQ_EARLY_RETIRE_EN is defined, return to T1 after the last active state:
- LDA after T5;
- OUT after T4;
- NOP after T4;
- ADD and SUB use the full T6.
REQ-028 SHALL, without SEQ_EARLY_RETIRE_EN, use a fixed six-state ring for every opcode.

Structure
REQ-029 SHALL place the opcode constants LDA/ADD/SUB/OUT/HLT, the one-hot T-state constants and a control-word struct typedef in shared package sap1_pkg.
REQ-030 SHALL use one sub-module, ring_counter (one-hot six-state counter with hold, wrap and load-T1), with decode kept in controller_sequencer.

Verification
REQ-031 SHALL verify reset: hold clr_n=0 for 2 cycles -> t_state=000001, all controls=0, clr_out=1; release clr_n -> ep=lm=1 on the first cycle.
REQ-032 SHALL verify LDA: opcode=0000, run=1 -> the T1-T6 control sequence per REQ-012/013, and cp high only at T2.
REQ-033 SHALL verify SUB: opcode=0010 -> at T6 su=eu=la=1, with lb=1 only at T5.
REQ-034 SHALL verify HLT: opcode=1111 -> hlt=1 from T4 and t_state=001000 held for 10 cycles with cp=0; then clr_n=0 for 1 cycle -> T1 with hlt=0.
REQ-035 SHALL verify pause: run=0 at T3 for 3 cycles -> t_state=000100 held and controls=0; after run=1 -> ce=li=1.
REQ-036 SHALL verify SEQ_EARLY_RETIRE_EN: OUT, LDA and ADD instructions take 4, 5 and 6 cycles respectively, T1 to next T1; without the macro, all take 6 cycles.
